ofmap_readback: RTL and testbench
=================================

OFMAP_READBACK -- requirements
Module: ofmap_readback

Interface
REQ-001 Parameter DEPTH, 128, result buffer entries (power of two).
REQ-002 Parameter BASE_ADDR, 32'h1004_3000, ICB base address of this block's 16-byte window.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 dout_valid  input  1  accelerator result strobe; one result per high cycle.
REQ-006 ofmap_out  input  32  accelerator result; bits [15:0] hold the fp16 value, bits [31:16] are ignored.
REQ-007 done  input  1  accelerator completion pulse.
REQ-008 icb_cmd_valid / icb_cmd_ready  input / output  1 / 1  ICB command handshake.
REQ-009 icb_cmd_read  input  1  1 = read, 0 = write.
REQ-010 icb_cmd_addr / icb_cmd_wdata / icb_cmd_wmask  input  32 / 32 / 4  ICB command fields; wmask is ignored.
REQ-011 icb_rsp_valid / icb_rsp_ready  output / input  1 / 1  ICB response handshake.
REQ-012 icb_rsp_rdata / icb_rsp_err  output  32 / 1  response data and error flag.
REQ-013 irq  output  1  level high while buffer count >= DEPTH/2 or the overflow flag is set.

Function
REQ-014 Register map (offset from BASE_ADDR):
- 0x0 DATA (R): pops the oldest entry; rdata = {16'h0, fp16}.
- 0x4 STATUS (R): {20'h0, count[7:0], overflow, done_seen, full, empty}.
- 0x8 CONTROL (W): bit0 = 1 clears the buffer, overflow and done_seen.
- 0xC reserved.
REQ-015 Push: on each cycle with dout_valid=1 and buffer not full, write ofmap_out[15:0] at the write pointer, advance the pointer modulo DEPTH, increment count.
REQ-016 dout_valid=1 while full with no pop in the same cycle: drop the value, set sticky overflow, leave count unchanged.
REQ-017 Push and pop in the same cycle when full: both occur, count unchanged, overflow not set.
REQ-018 Push and pop in the same cycle when empty: the pop returns the empty error (REQ-023); the push completes; count ends at 1.
REQ-019 done=1 sets sticky done_seen.
REQ-020 icb_cmd_ready = !icb_rsp_valid || icb_rsp_ready; at most one response is outstanding.
REQ-021 Command accepted in cycle N (cmd_valid & cmd_ready): icb_rsp_valid=1 in cycle N+1, with rdata/err registered.
- rsp fields hold stable until rsp_ready=1.
- Read side effects (pop) happen in cycle N.
REQ-022 Address outside the window, read of 0x8/0xC, or write of 0x0/0x4/0xC: err=1, rdata=0, no side effect.
REQ-023 DATA read while empty: err=1, rdata=0, no pop, pointers unchanged.
REQ-024 CONTROL write with bit0=1 in the same cycle as a push: clear wins, the push is dropped, count=0 next cycle.
- Write with bit0=0: err=0, no effect.
REQ-025 STATUS read returns the values before any same-cycle push or pop.
REQ-026 count width is clog2(DEPTH)+1 (8 bits at DEPTH=128).
- full = (count == DEPTH); empty = (count == 0).

Reset
REQ-027 While rst_n=0, asynchronously:
- pointers, count, overflow, done_seen = 0;
- icb_rsp_valid=0, icb_rsp_rdata=0, icb_rsp_err=0;
- icb_cmd_ready=1 (follows from REQ-020), irq=0.
- Buffer contents are undefined.
REQ-028 Reset asserted mid-transaction drops any pending response; there is no response to a command accepted before reset.

Verification
REQ-029 Push 120 results 16'h3C00+k (k=0..119), then 120 DATA reads -> rdata[15:0] = 16'h3C00+k in order, err=0; final STATUS = 32'h1 (empty).
REQ-030 Push 130 with no reads -> STATUS count=128, full=1, overflow=1, irq=1; 128 reads return the first 128 values; 129th read gets err=1, rdata=0.
REQ-031 DATA read with buffer empty -> err=1, rdata=0; a following push of 16'h4000 and a read -> rdata=32'h0000_4000, err=0.
REQ-032 Hold rsp_ready=0 for 5 cycles after a read -> rsp fields stable, cmd_ready=0 throughout; pop count stays 1.
REQ-033 CONTROL write 1 coincident with a dout_valid pulse -> next STATUS = 32'h1.
- done pulse, then STATUS read -> bit2=1; write to 0x0 -> err=1.
REQ-034 Assert rst_n=0 mid-stream with count=10 -> all outputs immediately at reset values (irq=0, rsp_valid=0); after release STATUS = 32'h1.

Source files
------------

// File: rtl/ofmap_readback.sv
// rtl/ofmap_readback.sv - accelerator result buffer with an ICB register window for fp16 readback
module ofmap_readback #(
  parameter int          DEPTH     = 128,
  parameter logic [31:0] BASE_ADDR = 32'h1004_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dout_valid,
  input  logic [31:0] ofmap_out,
  input  logic        done,
  input  logic        icb_cmd_valid,
  output logic        icb_cmd_ready,
  input  logic        icb_cmd_read,
  input  logic [31:0] icb_cmd_addr,
  input  logic [31:0] icb_cmd_wdata,
  input  logic [3:0]  icb_cmd_wmask,
  output logic        icb_rsp_valid,
  input  logic        icb_rsp_ready,
  output logic [31:0] icb_rsp_rdata,
  output logic        icb_rsp_err,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d, done_seen_q, done_seen_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;

  logic          full, empty, accept, in_win;
  logic          rd_data, rd_stat, wr_ctrl, clr, pop, push, ovf_set;
  logic [3:0]    off;
  logic [31:0]   status;
  logic          unused_bits;

  assign unused_bits = ^{icb_cmd_wmask, ofmap_out[31:16], icb_cmd_wdata[31:1]};

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign icb_cmd_ready = !rsp_valid_q || icb_rsp_ready;
  assign accept  = icb_cmd_valid && icb_cmd_ready;
  assign in_win  = (icb_cmd_addr[31:4] == BASE_ADDR[31:4]);
  assign off     = icb_cmd_addr[3:0];
  assign rd_data = accept && icb_cmd_read && in_win && (off == 4'h0);
  assign rd_stat = accept && icb_cmd_read && in_win && (off == 4'h4);
  assign wr_ctrl = accept && !icb_cmd_read && in_win && (off == 4'h8);
  assign clr     = wr_ctrl && icb_cmd_wdata[0];
  assign pop     = rd_data && !empty;
  // A pop frees a slot in the same cycle, so a full buffer still accepts the push; clear beats both.
  assign push    = dout_valid && (!full || pop) && !clr;
  assign ovf_set = dout_valid && full && !pop && !clr;
  assign status  = {20'h0, 8'(count_q), overflow_q, done_seen_q, full, empty};

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | ovf_set;
    done_seen_d = done_seen_q | done;
    if (clr) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      done_seen_d = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + {{(AW-1){1'b0}}, 1'b1};
      if (pop)  rptr_d = rptr_q + {{(AW-1){1'b0}}, 1'b1};
      count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q && !icb_rsp_ready;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
      if (pop) begin
        rsp_err_d   = 1'b0;
        rsp_rdata_d = {16'h0, mem_q[rptr_q]};
      end else if (rd_stat) begin
        rsp_err_d   = 1'b0;
        rsp_rdata_d = status;
      end else if (wr_ctrl) begin
        rsp_err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= ofmap_out[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      done_seen_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      done_seen_q <= done_seen_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign icb_rsp_valid = rsp_valid_q;
  assign icb_rsp_err   = rsp_err_q;
  assign icb_rsp_rdata = rsp_rdata_q;
  assign irq           = (count_q >= CW'(DEPTH / 2)) || overflow_q;

endmodule

// File: tb/tb_ofmap_readback.sv
// tb/tb_ofmap_readback.sv - directed self-checking bench for ofmap_readback
module tb_ofmap_readback;

  localparam logic [31:0] BASE = 32'h1004_3000;
  localparam logic [31:0] A_DATA = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dout_valid = 1'b0;
  logic [31:0] ofmap_out = '0;
  logic        done = 1'b0;
  logic        icb_cmd_valid = 1'b0;
  logic        icb_cmd_ready;
  logic        icb_cmd_read = 1'b0;
  logic [31:0] icb_cmd_addr = '0;
  logic [31:0] icb_cmd_wdata = '0;
  logic [3:0]  icb_cmd_wmask = '0;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready = 1'b1;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic        irq;

  int total = 0;
  int bad = 0;
  logic [31:0] rd;
  logic        er;

  ofmap_readback dut (
    .clk(clk), .rst_n(rst_n), .dout_valid(dout_valid), .ofmap_out(ofmap_out), .done(done),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
    .icb_rsp_err(icb_rsp_err), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One ICB command, optionally with a coincident result push; returns the registered response.
  task automatic cmd(input logic rdn, input logic [31:0] addr, input logic [31:0] wd,
                     input logic dv, input logic [15:0] dval,
                     output logic [31:0] rdata, output logic err);
    @(negedge clk);
    icb_cmd_valid = 1'b1; icb_cmd_read = rdn; icb_cmd_addr = addr; icb_cmd_wdata = wd;
    dout_valid = dv; ofmap_out = {16'hDEAD, dval};
    @(posedge clk); #1;
    icb_cmd_valid = 1'b0; dout_valid = 1'b0;
    rdata = icb_rsp_rdata; err = icb_rsp_err;
    chk("rsp_valid", {31'h0, icb_rsp_valid}, 32'h1);
  endtask

  task automatic push(input logic [15:0] v);
    @(negedge clk);
    dout_valid = 1'b1; ofmap_out = {16'hBEEF, v};
    @(posedge clk); #1;
    dout_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_rsp_valid", {31'h0, icb_rsp_valid}, 32'h0);
    chk("rst_cmd_ready", {31'h0, icb_cmd_ready}, 32'h1);
    chk("rst_irq",       {31'h0, irq}, 32'h0);
    chk("rst_rdata",     icb_rsp_rdata, 32'h0);
    chk("rst_err",       {31'h0, icb_rsp_err}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmd(1'b1, A_STAT, 0, 1'b0, 0, rd, er);
    chk("init_status", rd, 32'h1);

    // In-order drain of 120 results
    for (int k = 0; k < 120; k++) push(16'h3C00 + 16'(k));
    cmd(1'b1, A_STAT, 0, 1'b0, 0, rd, er);
    chk("status_120", rd, 32'h780);
    chk("irq_120", {31'h0, irq}, 32'h1);
    for (int k = 0; k < 120; k++) begin
      cmd(1'b1, A_DATA, 0, 1'b0, 0, rd, er);
      chk("drain120_data", rd, 32'h3C00 + 32'(k));
      chk("drain120_err", {31'h0, er}, 32'h0);
    end
    cmd(1'b1, A_STAT, 0, 1'b0, 0, rd, er);
    chk("status_after_drain", rd, 32'h1);
    chk("irq_after_drain", {31'h0, irq}, 32'h0);

    // Overfill: 130 pushes into 128 slots
    for (int k = 0; k < 130; k++) push(16'h1000 + 16'(k));
    cmd(1'b1, A_STAT, 0, 1'b0, 0, rd, er);
    chk("status_full", rd, 32'h80A);
    chk("irq_full", {31'h0, irq}, 32'h1);
    for (int k = 0; k < 128; k++) begin
      cmd(1'b1, A_DATA, 0, 1'b0, 0, rd, er);
      chk("drain128_data", rd, 32'h1000 + 32'(k));
    end
    cmd(1'b1, A_DATA, 0, 1'b0, 0, rd, er);
    chk("read129_rdata", rd, 32'h0);
    chk("read129_err", {31'h0, er}, 32'h1);
    cmd(1'b1, A_STAT, 0, 1'b0, 0, rd, er);
    chk("status_ovf_empty", rd, 32'h9);
    chk("irq_ovf", {31'h0, irq}, 32'h1);
    cmd(1'b0, A_CTRL, 32'h1, 1'b0, 0, rd, er);
    chk("ctrl_clear_err", {31'h0, er}, 32'h0);
    cmd(1'b1, A_STAT, 0, 1'b0, 0, rd, er);
    chk("status_cleared", rd, 32'h1);

    // Empty reads, alone and coincident with a push
    cmd(1'b1, A_DATA, 0, 1'b0, 0, rd, er);
    chk("empty_read_err", {31'h0, er}, 32'h1);
    chk("empty_read_rdata", rd, 32'h0);
    cmd(1'b1, A_DATA, 0, 1'b1, 16'h4000, rd, er);
    chk("empty_pushpop_err", {31'h0, er}, 32'h1);
    cmd(1'b1, A_STAT, 0, 1'b0, 0, rd, er);
    chk("empty_pushpop_status", rd, 32'h10);
    cmd(1'b1, A_DATA, 0, 1'b0, 0, rd, er);
    chk("read_4000", rd, 32'h0000_4000);
    chk("read_4000_err", {31'h0, er}, 32'h0);

    // Response backpressure: fields hold, no second pop
    push(16'h5555); push(16'h6666);
    @(negedge clk);
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = A_DATA; icb_rsp_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'h0, icb_rsp_valid}, 32'h1);
      chk("stall_rdata", icb_rsp_rdata, 32'h5555);
      chk("stall_err", {31'h0, icb_rsp_err}, 32'h0);
      chk("stall_cmd_ready", {31'h0, icb_cmd_ready}, 32'h0);
    end
    icb_cmd_valid = 1'b0; icb_rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", {31'h0, icb_rsp_valid}, 32'h0);
    cmd(1'b1, A_STAT, 0, 1'b0, 0, rd, er);
    chk("stall_one_pop", rd, 32'h10);
    cmd(1'b1, A_DATA, 0, 1'b0, 0, rd, er);
    chk("stall_next_data", rd, 32'h6666);

    // Clear vs coincident push, done flag, illegal accesses
    push(16'h1111);
    cmd(1'b0, A_CTRL, 32'h1, 1'b1, 16'h7777, rd, er);
    cmd(1'b1, A_STAT, 0, 1'b0, 0, rd, er);
    chk("clear_beats_push", rd, 32'h1);
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
    cmd(1'b1, A_STAT, 0, 1'b0, 0, rd, er);
    chk("done_seen", rd, 32'h5);
    cmd(1'b0, A_CTRL, 32'h0, 1'b0, 0, rd, er);
    chk("ctrl_zero_err", {31'h0, er}, 32'h0);
    cmd(1'b1, A_STAT, 0, 1'b0, 0, rd, er);
    chk("ctrl_zero_noeffect", rd, 32'h5);
    cmd(1'b0, A_DATA, 32'h1, 1'b0, 0, rd, er);
    chk("wr_data_err", {31'h0, er}, 32'h1);
    cmd(1'b1, A_CTRL, 0, 1'b0, 0, rd, er);
    chk("rd_ctrl_err", {31'h0, er}, 32'h1);
    cmd(1'b1, BASE + 32'h10, 0, 1'b0, 0, rd, er);
    chk("out_of_window_err", {31'h0, er}, 32'h1);
    chk("out_of_window_rdata", rd, 32'h0);

    // Reset mid-stream with a pending response
    cmd(1'b0, A_CTRL, 32'h1, 1'b0, 0, rd, er);
    for (int k = 0; k < 10; k++) push(16'h2000 + 16'(k));
    cmd(1'b1, A_STAT, 0, 1'b0, 0, rd, er);
    chk("status_10", rd, 32'hA0);
    @(negedge clk);
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = A_DATA; icb_rsp_ready = 1'b0;
    dout_valid = 1'b1; ofmap_out = 32'h0000_2222;
    @(posedge clk); #2;
    chk("pending_before_rst", {31'h0, icb_rsp_valid}, 32'h1);
    rst_n = 1'b0; #1;
    chk("rst_mid_rsp_valid", {31'h0, icb_rsp_valid}, 32'h0);
    chk("rst_mid_irq", {31'h0, irq}, 32'h0);
    chk("rst_mid_cmd_ready", {31'h0, icb_cmd_ready}, 32'h1);
    chk("rst_mid_rdata", icb_rsp_rdata, 32'h0);
    icb_cmd_valid = 1'b0; dout_valid = 1'b0; icb_rsp_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("no_rsp_after_rst", {31'h0, icb_rsp_valid}, 32'h0);
    cmd(1'b1, A_STAT, 0, 1'b0, 0, rd, er);
    chk("status_after_rst", rd, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
